// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer block: register offsets, CTRL field positions,
// reset constants and the byte-enable merge helper.
package bus_timer_pkg;

    localparam logic [11:0] TIMER_MTIME_LO    = 12'h000;
    localparam logic [11:0] TIMER_MTIME_HI    = 12'h004;
    localparam logic [11:0] TIMER_MTIMECMP_LO = 12'h008;
    localparam logic [11:0] TIMER_MTIMECMP_HI = 12'h00C;
    localparam logic [11:0] TIMER_CTRL        = 12'h010;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Register index as seen on addr[4:2].
    typedef enum logic [2:0] {
        REG_MTIME_LO    = TIMER_MTIME_LO[4:2],
        REG_MTIME_HI    = TIMER_MTIME_HI[4:2],
        REG_MTIMECMP_LO = TIMER_MTIMECMP_LO[4:2],
        REG_MTIMECMP_HI = TIMER_MTIMECMP_HI[4:2],
        REG_CTRL        = TIMER_CTRL[4:2]
    } timer_reg_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Device-side bus port of the machine timer.
// Handshake: req is a single-cycle strobe that is always accepted (no ready/gnt);
// exactly one rvalid follows one cycle later carrying rdata and err.
interface bus_timer_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic                    timer_req_i;
    logic                    timer_we_i;
    logic [DataWidth/8-1:0]  timer_be_i;
    logic [AddressWidth-1:0] timer_addr_i;
    logic [DataWidth-1:0]    timer_wdata_i;
    logic                    timer_rvalid_o;
    logic [DataWidth-1:0]    timer_rdata_o;
    logic                    timer_err_o;

    modport master (
        output timer_req_i, timer_we_i, timer_be_i, timer_addr_i, timer_wdata_i,
        input  timer_rvalid_o, timer_rdata_o, timer_err_o
    );

    modport slave (
        input  timer_req_i, timer_we_i, timer_be_i, timer_addr_i, timer_wdata_i,
        output timer_rvalid_o, timer_rdata_o, timer_err_o
    );
endinterface

// File: rtl/bus_timer_prescaler.sv
// Tick generator for the timer: one tick every presc+1 enabled cycles.
// The count restarts a full period whenever load is seen or en is low.
module bus_timer_prescaler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] presc,
    output logic       tick
);
    logic [7:0] cnt_q;

    assign tick = en && !load && (cnt_q == 8'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (load || !en) begin
            cnt_q <= presc;
        end else if (cnt_q == 8'd0) begin
            cnt_q <= presc;
        end else begin
            cnt_q <= cnt_q - 8'd1;
        end
    end
endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit RISC-V machine timer (mtime/mtimecmp) with level interrupt.
// Optional prescaler on CTRL[15:8] is built when TIMER_PRESCALER_EN is defined.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic           CLK,
    input  logic           RST,
    bus_timer_if.slave     bus,
    output logic           timer_intr_o
);
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic [31:0]          shadow_q;
    logic                 en_q, en_d;
    logic [7:0]           presc_val;
    logic                 tick;
    logic                 rvalid_q, err_q, intr_q;
    logic [DataWidth-1:0] rdata_q;

    timer_reg_e  reg_idx;
    logic        reg_hit, wr_en, rd_en, ctrl_wr;
    logic [31:0] live_val, read_val, ctrl_val, wdata_m;
    logic        unused_addr;

    assign reg_idx     = timer_reg_e'(bus.timer_addr_i[4:2]);
    assign reg_hit     = bus.timer_addr_i[4:2] <= REG_CTRL;
    assign wr_en       = bus.timer_req_i && bus.timer_we_i && reg_hit;
    assign rd_en       = bus.timer_req_i && !bus.timer_we_i && reg_hit;
    assign ctrl_wr     = wr_en && (reg_idx == REG_CTRL);
    assign unused_addr = ^{bus.timer_addr_i[AddressWidth-1:5], bus.timer_addr_i[1:0]};

    always_comb begin
        ctrl_val                                = '0;
        ctrl_val[CTRL_EN_BIT]                   = en_q;
        ctrl_val[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_val;
    end

    always_comb begin
        live_val = '0;
        case (reg_idx)
            REG_MTIME_LO:    live_val = mtime_q[31:0];
            REG_MTIME_HI:    live_val = mtime_q[63:32];
            REG_MTIMECMP_LO: live_val = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: live_val = mtimecmp_q[63:32];
            REG_CTRL:        live_val = ctrl_val;
            default:         live_val = '0;
        endcase
    end

    // MTIME_HI reads the half captured by the last MTIME_LO read, so a LO/HI pair is coherent.
    assign read_val = (reg_idx == REG_MTIME_HI) ? shadow_q : live_val;
    assign wdata_m  = be_merge(live_val, bus.timer_wdata_i, bus.timer_be_i);

    // A bus write to either mtime half replaces the increment; the other half keeps its old value.
    always_comb begin
        mtime_d = mtime_q;
        if (en_q && tick) mtime_d = mtime_q + 64'd1;
        if (wr_en && reg_idx == REG_MTIME_LO) mtime_d = {mtime_q[63:32], wdata_m};
        if (wr_en && reg_idx == REG_MTIME_HI) mtime_d = {wdata_m, mtime_q[31:0]};
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_en && reg_idx == REG_MTIMECMP_LO) mtimecmp_d[31:0]  = wdata_m;
        if (wr_en && reg_idx == REG_MTIMECMP_HI) mtimecmp_d[63:32] = wdata_m;
    end

    assign en_d = ctrl_wr ? wdata_m[CTRL_EN_BIT] : en_q;

`ifdef TIMER_PRESCALER_EN
    logic [7:0] presc_q, presc_d;

    assign presc_d   = ctrl_wr ? wdata_m[CTRL_PRESC_MSB:CTRL_PRESC_LSB] : presc_q;
    assign presc_val = presc_q;

    always_ff @(posedge CLK) begin
        if (RST) presc_q <= '0;
        else     presc_q <= presc_d;
    end

    bus_timer_prescaler u_prescaler (
        .CLK   (CLK),
        .RST   (RST),
        .en    (en_q),
        .load  (ctrl_wr),
        .presc (presc_d),
        .tick  (tick)
    );
`else
    assign presc_val = '0;
    assign tick      = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            shadow_q   <= '0;
            en_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            rvalid_q   <= bus.timer_req_i;
            rdata_q    <= rd_en ? read_val : '0;
            err_q      <= bus.timer_req_i && !reg_hit;
            intr_q     <= (mtime_q >= mtimecmp_q);
            if (rd_en && reg_idx == REG_MTIME_LO) shadow_q <= mtime_q[63:32];
        end
    end

    assign bus.timer_rvalid_o = rvalid_q;
    assign bus.timer_rdata_o  = rdata_q;
    assign bus.timer_err_o    = err_q;
    assign timer_intr_o       = intr_q;
endmodule

// File: tb/tb_bus_timer.sv
// Directed and randomized bench for bus_timer against a per-cycle behavioural model.
// Honours TIMER_PRESCALER_EN the same way the design does.
`timescale 1ns/1ps
module tb_bus_timer;
  logic CLK = 1'b0;
  logic RST;
  logic timer_intr;

  bus_timer_if bus ();

  bus_timer dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .timer_intr_o (timer_intr)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  // ---------------- scoreboard: {err, rdata} per accepted request ----------------
  logic [32:0] exp_q[$];

  logic [63:0] m_time, m_cmp;
  logic [31:0] m_sh;
  logic        m_en;
  logic [7:0]  m_presc;
  int          m_ecnt;
  logic        m_intr, m_rvalid;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (wd & mask) | (old_v & ~mask);
  endfunction

  // Reference model: state after each rising edge, from the register-map rules.
  always @(posedge CLK) begin : ref_model
    logic [63:0] t_old;
    logic [31:0] cur, mw, ctrl_word;
    logic [2:0]  idx;
    logic        tick, ctrl_wr, hit, req, we;
    if (RST) begin
      m_time = '0; m_cmp = '1; m_sh = '0; m_en = 1'b0; m_presc = '0;
      m_ecnt = 0; m_intr = 1'b0; m_rvalid = 1'b0;
      exp_q.delete();
    end else begin
      req       = bus.timer_req_i;
      we        = bus.timer_we_i;
      idx       = bus.timer_addr_i[4:2];
      hit       = (idx <= 3'd4);
      t_old     = m_time;
      ctrl_word = {16'h0, m_presc, 7'h0, m_en};
      m_intr    = (m_time >= m_cmp);
      m_rvalid  = req;
      ctrl_wr   = req && we && (idx == 3'd4);
`ifdef TIMER_PRESCALER_EN
      if (ctrl_wr || !m_en) begin
        m_ecnt = 0;
        tick   = 1'b0;
      end else begin
        m_ecnt = m_ecnt + 1;
        tick   = (m_ecnt % (int'(m_presc) + 1)) == 0;
      end
`else
      tick = 1'b1;
`endif
      if (m_en && tick) m_time = m_time + 64'd1;
      if (req) begin
        case (idx)
          3'd0:    cur = t_old[31:0];
          3'd1:    cur = we ? t_old[63:32] : m_sh;
          3'd2:    cur = m_cmp[31:0];
          3'd3:    cur = m_cmp[63:32];
          3'd4:    cur = ctrl_word;
          default: cur = 32'h0;
        endcase
        exp_q.push_back({!hit, (!we && hit) ? cur : 32'h0});
        if (we && hit) begin
          mw = merge(cur, bus.timer_wdata_i, bus.timer_be_i);
          case (idx)
            3'd0: m_time = {t_old[63:32], mw};
            3'd1: m_time = {mw, t_old[31:0]};
            3'd2: m_cmp[31:0] = mw;
            3'd3: m_cmp[63:32] = mw;
            default: begin
              m_en = mw[0];
`ifdef TIMER_PRESCALER_EN
              m_presc = mw[15:8];
`endif
            end
          endcase
        end
        if (!we && idx == 3'd0) m_sh = t_old[63:32];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; then compare every output against the model.
  task automatic cyc();
    logic [32:0] e;
    @(posedge CLK);
    #1;
    chk("rvalid", 32'(bus.timer_rvalid_o), 32'(m_rvalid));
    chk("intr", 32'(timer_intr), 32'(m_intr));
    if (m_rvalid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdata", bus.timer_rdata_o, e[31:0]);
      chk("err", 32'(bus.timer_err_o), 32'(e[32]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_drive();
    bus.timer_req_i   = 1'b0;
    bus.timer_we_i    = 1'b0;
    bus.timer_be_i    = 4'h0;
    bus.timer_addr_i  = 32'h0;
    bus.timer_wdata_i = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [31:0] off, input logic [3:0] be,
                       input logic [31:0] wd);
    bus.timer_req_i   = 1'b1;
    bus.timer_we_i    = we;
    bus.timer_be_i    = be;
    bus.timer_addr_i  = 32'h8000_2000 | off;
    bus.timer_wdata_i = wd;
  endtask

  task automatic wr(input logic [31:0] off, input logic [3:0] be, input logic [31:0] wd,
                    output logic err);
    drive(1'b1, off, be, wd);
    cyc();
    err = bus.timer_err_o;
    idle_drive();
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] data, output logic err);
    drive(1'b0, off, 4'h0, 32'h0);
    cyc();
    data = bus.timer_rdata_o;
    err  = bus.timer_err_o;
    idle_drive();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d, d2;
    logic        e;
    int          waited;

    RST = 1'b1;
    idle_drive();
    idle(3);
    chk("rst_rvalid", 32'(bus.timer_rvalid_o), 32'h0);
    chk("rst_intr", 32'(timer_intr), 32'h0);
    RST = 1'b0;

    // Reset values of the compare register and counter
    rd(32'h08, d, e); chk("t1_cmp_lo", d, 32'hFFFF_FFFF); chk("t1_err", 32'(e), 32'h0);
    rd(32'h0C, d, e); chk("t1_cmp_hi", d, 32'hFFFF_FFFF);
    rd(32'h00, d, e); chk("t1_mtime_lo", d, 32'h0);

    // Interrupt raise at mtimecmp=20 and clear by raising mtimecmp
    wr(32'h08, 4'hF, 32'd20, e);
    wr(32'h0C, 4'hF, 32'd0, e);
    wr(32'h10, 4'hF, 32'h1, e);
    waited = 0;
    while (timer_intr !== 1'b1 && waited < 100) begin
      cyc();
      waited++;
    end
    chk("t2_intr_rise", 32'(timer_intr), 32'h1);
    wr(32'h08, 4'hF, 32'd100, e);
    chk("t2_intr_hold", 32'(timer_intr), 32'h1);
    cyc();
    chk("t2_intr_fall", 32'(timer_intr), 32'h0);

    // Carry across the 32-bit boundary with a coherent LO/HI read
    wr(32'h10, 4'hF, 32'h0, e);
    wr(32'h04, 4'hF, 32'h0, e);
    wr(32'h00, 4'hF, 32'hFFFF_FFFE, e);
    wr(32'h10, 4'hF, 32'h1, e);
    idle(3);
    rd(32'h00, d, e); chk("t3_lo", d, 32'h0000_0001);
    rd(32'h04, d, e); chk("t3_hi", d, 32'h0000_0001);

    // Byte-lane write racing an increment; be=0 changes nothing
    wr(32'h00, 4'b0010, 32'hAABB_CCDD, e);
    rd(32'h00, d, e); chk("t4_lo_byte1", d, 32'h0000_CC03);
    wr(32'h04, 4'b0000, 32'hFFFF_FFFF, e);
    chk("t4_be0_rvalid", 32'(bus.timer_rvalid_o), 32'h1);
    rd(32'h00, d, e);
    rd(32'h04, d, e); chk("t4_be0_hi", d, 32'h0000_0001);

    // Unmapped offsets and back-to-back requests
    rd(32'h14, d, e); chk("t5_rd_data", d, 32'h0); chk("t5_rd_err", 32'(e), 32'h1);
    wr(32'h18, 4'hF, 32'h1234_5678, e); chk("t5_wr_err", 32'(e), 32'h1);
    rd(32'h08, d, e); chk("t5_cmp_kept", d, 32'd100);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'(i * 4), 4'h0, 32'h0);
      cyc();
      chk("t5_b2b_rvalid", 32'(bus.timer_rvalid_o), 32'h1);
    end
    idle_drive();
    cyc();
    chk("t5_b2b_end", 32'(bus.timer_rvalid_o), 32'h0);

    // Prescaler / CTRL readback
    wr(32'h10, 4'hF, 32'h0000_0301, e);
    rd(32'h10, d, e);
`ifdef TIMER_PRESCALER_EN
    chk("t6_ctrl", d, 32'h0000_0301);
`else
    chk("t6_ctrl", d, 32'h0000_0001);
`endif
    rd(32'h00, d, e);
    idle(7);
    rd(32'h00, d2, e);
`ifdef TIMER_PRESCALER_EN
    chk("t6_rate", d2 - d, 32'd2);
`else
    chk("t6_rate", d2 - d, 32'd8);
`endif

    // Reset in the same cycle as a request drops the response
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    RST = 1'b1;
    cyc();
    chk("t7_rst_drop", 32'(bus.timer_rvalid_o), 32'h0);
    idle_drive();
    RST = 1'b0;
    rd(32'h08, d, e); chk("t7_cmp_reset", d, 32'hFFFF_FFFF);
    rd(32'h10, d, e); chk("t7_ctrl_reset", d, 32'h0);

    // Randomized traffic, including occasional resets
    for (int n = 0; n < 600; n++) begin
      RST = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 1) begin
        drive(1'(($urandom_range(0, 2)) == 0),
              32'($urandom_range(0, 7) * 4) | (32'($urandom_range(0, 127)) << 5)
                | 32'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom());
      end else begin
        idle_drive();
      end
      cyc();
    end
    RST = 1'b0;
    idle_drive();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
